// File: rtl/irq_controller_if.sv
// Bus between the interrupt controller and its environment: peripheral
// request lines, mask write port and the core's acknowledge/EOI handshake.
interface irq_controller_if #(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0] irq_req;
  logic               mask_wr;
  logic [NUM_SRC-1:0] mask_in;
  logic               inta;
  logic               eoi;
  logic               interrupt;
  logic [7:0]         vector;
  logic [NUM_SRC-1:0] pending;
  logic               busy;

  modport master (
    output irq_req, mask_wr, mask_in, inta, eoi,
    input  interrupt, vector, pending, busy
  );

  modport slave (
    input  irq_req, mask_wr, mask_in, inta, eoi,
    output interrupt, vector, pending, busy
  );
endinterface

// File: rtl/irq_controller.sv
// Prioritised interrupt controller: synchronises and edge-detects requests,
// masks and arbitrates them (index 0 highest) and hands one at a time to the core.
module irq_controller #(
  parameter int         NUM_SRC  = 4,
  parameter logic [7:0] VEC_BASE = 8'h20
) (
  input  logic             clk,
  input  logic             reset,
  irq_controller_if.slave  bus
);

  localparam int ID_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [NUM_SRC-1:0] sync1_q, sync2_q, edge_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               interrupt_q, interrupt_d;
  logic [7:0]         vector_q, vector_d;
  logic               busy_q, busy_d;

  logic [NUM_SRC-1:0] rise_s;
  logic [NUM_SRC-1:0] eligible_s;
  logic [NUM_SRC-1:0] clr_s;
  logic [ID_W-1:0]    sel_s;
  logic               any_s;

  function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_SRC-1:0] v);
    logic [ID_W-1:0] idx;
    idx = {ID_W{1'b0}};
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      idx = v[i] ? ID_W'(i) : idx;
    end
    return idx;
  endfunction

  assign rise_s     = sync2_q & ~edge_q;
  assign eligible_s = pending_q & ~mask_q;
  assign any_s      = |eligible_s;
  assign sel_s      = lowest_idx(eligible_s);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; inta/eoi only matter in the state that expects them
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_s) state_d = REQ;
        else       state_d = IDLE;
      end
      REQ: begin
        if (!any_s)    state_d = IDLE;
        else if (bus.inta) state_d = SERVICE;
        else           state_d = REQ;
      end
      SERVICE: begin
        if (bus.eoi) state_d = IDLE;
        else         state_d = SERVICE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic: id tracking, acknowledge side effects
  always_comb begin
    id_d     = id_q;
    vector_d = vector_q;
    clr_s    = {NUM_SRC{1'b0}};
    case (state_q)
      IDLE: begin
        if (any_s) id_d = sel_s;
        else       id_d = id_q;
      end
      REQ: begin
        if (any_s && bus.inta) begin
          clr_s    = NUM_SRC'(1'b1) << id_q;
          vector_d = VEC_BASE + {3'b000, id_q, 2'b00};
        end else if (any_s) begin
          id_d = sel_s;
        end else begin
          id_d = id_q;
        end
      end
      SERVICE: begin
        id_d = id_q;
      end
      default: begin
        id_d = {ID_W{1'b0}};
      end
    endcase
    // A new edge on the source being acknowledged wins over its clear
    pending_d   = (pending_q & ~clr_s) | rise_s;
    interrupt_d = (state_d == REQ);
    busy_d      = (state_d == SERVICE);
    if (bus.mask_wr) mask_d = bus.mask_in;
    else             mask_d = mask_q;
  end

  // Synchronisers, edge detect and all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= {NUM_SRC{1'b0}};
      sync2_q     <= {NUM_SRC{1'b0}};
      edge_q      <= {NUM_SRC{1'b0}};
      pending_q   <= {NUM_SRC{1'b0}};
      mask_q      <= {NUM_SRC{1'b1}};
      id_q        <= {ID_W{1'b0}};
      interrupt_q <= 1'b0;
      vector_q    <= 8'h00;
      busy_q      <= 1'b0;
    end else begin
      sync1_q     <= bus.irq_req;
      sync2_q     <= sync1_q;
      edge_q      <= sync2_q;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      id_q        <= id_d;
      interrupt_q <= interrupt_d;
      vector_q    <= vector_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.interrupt = interrupt_q;
  assign bus.vector    = vector_q;
  assign bus.pending   = pending_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: directed scenarios plus randomised
// request/mask rounds checked against a set-based reference model.
module tb_irq_controller;

  logic clk;
  logic reset;
  int   checks = 0;
  int   passes = 0;

  typedef struct {
    logic [7:0] vec;
    logic [3:0] pend;
  } exp_t;
  exp_t sb_q[$];

  irq_controller_if #(.NUM_SRC(4)) bus ();

  irq_controller #(.NUM_SRC(4), .VEC_BASE(8'h20)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passes++;
  endtask

  // Monitor: every acknowledge (busy rising) is compared with the oldest expectation
  initial begin
    logic busy_prev;
    exp_t e;
    busy_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.busy === 1'b1 && busy_prev === 1'b0) begin
        checks++;
        if (sb_q.size() == 0) begin
          $display("FAIL ack_unexpected: vector=%0h with no expected acknowledge", bus.vector);
        end else begin
          e = sb_q.pop_front();
          if (bus.vector !== e.vec || bus.pending !== e.pend)
            $display("FAIL ack: vector=%0h pending=%0b expected vector=%0h pending=%0b",
                     bus.vector, bus.pending, e.vec, e.pend);
          else passes++;
        end
      end
      busy_prev = bus.busy;
    end
  end

  task automatic wait_int(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.interrupt === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      $display("FAIL wait_interrupt: interrupt=0 expected 1 within 40 cycles");
    end
  endtask

  task automatic ack(input logic [7:0] v, input logic [3:0] p);
    exp_t e;
    e.vec  = v;
    e.pend = p;
    sb_q.push_back(e);
    @(negedge clk);
    bus.inta = 1'b1;
    @(negedge clk);
    bus.inta = 1'b0;
  endtask

  task automatic do_eoi();
    @(negedge clk);
    bus.eoi = 1'b1;
    @(negedge clk);
    bus.eoi = 1'b0;
    chk("busy_after_eoi", 32'(bus.busy), 32'd0);
  endtask

  task automatic set_mask(input logic [3:0] m);
    @(negedge clk);
    bus.mask_wr = 1'b1;
    bus.mask_in = m;
    @(negedge clk);
    bus.mask_wr = 1'b0;
  endtask

  // Reference model: serve every unmasked pending source, lowest index first
  task automatic drain(inout int unsigned pend, input int unsigned msk);
    int i;
    bit ok;
    while ((pend & ~msk) != 32'd0) begin
      i = 0;
      for (int k = 3; k >= 0; k--) begin
        if ((((pend & ~msk) >> k) & 32'd1) != 32'd0) i = k;
      end
      pend = pend & ~(32'd1 << i);
      wait_int(ok);
      if (!ok) return;
      ack(8'(32 + 4 * i), 4'(pend));
      do_eoi();
    end
  endtask

  initial begin
    bit ok;
    int unsigned pend, msk, req;
    reset       = 1'b1;
    bus.irq_req = 4'b0000;
    bus.mask_wr = 1'b0;
    bus.mask_in = 4'b0000;
    bus.inta    = 1'b0;
    bus.eoi     = 1'b0;

    // Reset window with requests toggling
    #200 reset = 1'b0;
    #1;
    chk("rst_outputs", {23'd0, bus.interrupt, bus.vector}, 32'd0);
    chk("rst_pend_busy", {27'd0, bus.busy, bus.pending}, 32'd0);
    #200 bus.irq_req = 4'b1111;
    #100;
    chk("rst_hold", {19'd0, bus.interrupt, bus.busy, bus.vector, bus.pending}, 32'd0);
    bus.irq_req = 4'b0000;
    #199 reset = 1'b1;

    // Mask resets to all-ones: requests pend but never interrupt
    @(negedge clk) bus.irq_req = 4'b1111;
    repeat (6) @(negedge clk);
    chk("masked_pending", 32'(bus.pending), 32'hF);
    chk("masked_no_int", 32'(bus.interrupt), 32'd0);
    bus.irq_req = 4'b0000;
    @(negedge clk) reset = 1'b0;
    #3 chk("async_rst_pending", 32'(bus.pending), 32'd0);
    @(negedge clk) reset = 1'b1;

    // Single source latency and acknowledge
    set_mask(4'b0000);
    @(negedge clk) bus.irq_req = 4'b0100;
    @(posedge clk);
    @(posedge clk); #1 chk("lat_pend_n1", 32'(bus.pending), 32'd0);
    @(posedge clk); #1 chk("lat_pend_n2", 32'(bus.pending), 32'h4);
    chk("lat_int_n2", 32'(bus.interrupt), 32'd0);
    @(posedge clk); #1 chk("lat_int_n3", 32'(bus.interrupt), 32'd1);
    ack(8'h28, 4'b0000);
    chk("busy_in_service", 32'(bus.busy), 32'd1);
    chk("int_low_in_service", 32'(bus.interrupt), 32'd0);
    do_eoi();
    bus.irq_req = 4'b0000;
    repeat (4) @(negedge clk);

    // Simultaneous requests: priority order
    bus.irq_req = 4'b1010;
    wait_int(ok);
    ack(8'h24, 4'b1000);
    do_eoi();
    wait_int(ok);
    ack(8'h2C, 4'b0000);
    do_eoi();
    bus.irq_req = 4'b0000;
    repeat (4) @(negedge clk);

    // Higher priority arrives while in REQ
    bus.irq_req = 4'b1000;
    wait_int(ok);
    bus.irq_req = 4'b1001;
    repeat (5) @(negedge clk);
    ack(8'h20, 4'b1000);
    do_eoi();
    wait_int(ok);
    ack(8'h2C, 4'b0000);
    do_eoi();
    bus.irq_req = 4'b0000;
    repeat (4) @(negedge clk);

    // Masking the requesting source while in REQ
    bus.irq_req = 4'b0010;
    wait_int(ok);
    @(negedge clk);
    bus.mask_wr = 1'b1;
    bus.mask_in = 4'b0010;
    @(posedge clk); #1 chk("mask_edge_int", 32'(bus.interrupt), 32'd1);
    @(negedge clk) bus.mask_wr = 1'b0;
    @(posedge clk); #1 chk("mask_int_drop", 32'(bus.interrupt), 32'd0);
    chk("mask_keep_pend", 32'(bus.pending), 32'h2);
    set_mask(4'b0000);
    wait_int(ok);
    ack(8'h24, 4'b0000);
    do_eoi();
    bus.irq_req = 4'b0000;
    repeat (4) @(negedge clk);

    // Randomised rounds: level-held requests under a random mask
    for (int r = 0; r < 12; r++) begin
      msk = $urandom_range(0, 15);
      req = $urandom_range(1, 15);
      set_mask(4'(msk));
      @(negedge clk) bus.irq_req = 4'(req);
      repeat (6) @(negedge clk);
      pend = req;
      chk("rnd_pending", 32'(bus.pending), pend);
      chk("rnd_int", 32'(bus.interrupt), 32'((pend & ~msk) != 32'd0));
      drain(pend, msk);
      set_mask(4'b0000);
      drain(pend, 32'd0);
      repeat (3) @(negedge clk);
      chk("rnd_idle", {27'd0, bus.interrupt, bus.pending}, 32'd0);
      bus.irq_req = 4'b0000;
      repeat (4) @(negedge clk);
    end

    // Reset during SERVICE, then a stray acknowledge
    bus.irq_req = 4'b0100;
    wait_int(ok);
    ack(8'h28, 4'b0000);
    bus.irq_req = 4'b0101;
    repeat (3) @(negedge clk);
    chk("svc_busy", 32'(bus.busy), 32'd1);
    chk("svc_pend", 32'(bus.pending), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("svc_rst_clear", {19'd0, bus.interrupt, bus.busy, bus.vector, bus.pending}, 32'd0);
    bus.irq_req = 4'b0000;
    @(negedge clk) reset = 1'b1;
    @(negedge clk) bus.inta = 1'b1;
    @(negedge clk) bus.inta = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray_inta", {23'd0, bus.busy, bus.vector}, 32'd0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
